// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: merges same-cycle pipeline writebacks with
// in-order load responses, tracks pending load destinations and blocks WAW hazards.
module wb_port_arbiter #(
    parameter int XLEN     = 32,
    parameter int REG_BITS = 5,
    parameter int LD_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          io_pipe_valid,
    input  logic [1:0]                    io_pipe_sel,
    input  logic [REG_BITS-1:0]           io_pipe_rd,
    input  logic                          io_pipe_wen,
    input  logic [XLEN-1:0]               io_pipe_alu,
    input  logic [XLEN-1:0]               io_pipe_csr,
    input  logic [XLEN-1:0]               io_pipe_pc4,
    output logic                          io_pipe_ready,
    input  logic                          io_ld_issue_valid,
    input  logic [REG_BITS-1:0]           io_ld_issue_rd,
    output logic                          io_ld_issue_ready,
    input  logic                          io_ld_resp_valid,
    input  logic [XLEN-1:0]               io_ld_resp_data,
    output logic                          io_ld_resp_ready,
    output logic                          io_rf_wen,
    output logic [REG_BITS-1:0]           io_rf_waddr,
    output logic [XLEN-1:0]               io_rf_wdata,
    output logic [$clog2(LD_DEPTH):0]     io_ld_pending
);

    localparam int PTR_W = $clog2(LD_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        GRANT_PIPE = 1'b0,
        GRANT_LD   = 1'b1
    } grant_t;

    logic [REG_BITS-1:0] q_rd [LD_DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;
    grant_t              last_grant;

    logic                pipe_wr;
    logic                rd_match;
    logic                hazard;
    logic                pipe_req;
    logic                ld_req;
    logic                grant_pipe;
    logic                grant_ld;
    logic                push;
    logic                pop;
    logic [XLEN-1:0]     pipe_data;

    // An entry is live when its distance from head (mod depth) is below count.
    always_comb begin
        rd_match = 1'b0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            if ({1'b0, PTR_W'(PTR_W'(i) - head)} < count && q_rd[i] == io_pipe_rd)
                rd_match = 1'b1;
        end
    end

    always_comb begin
        pipe_data = io_pipe_alu;
        case (io_pipe_sel)
            2'd1:    pipe_data = io_pipe_csr;
            2'd2:    pipe_data = io_pipe_pc4;
            default: pipe_data = io_pipe_alu;
        endcase
    end

    always_comb begin
        pipe_wr    = io_pipe_valid & io_pipe_wen;
        hazard     = pipe_wr & (io_pipe_rd != '0) & rd_match;
        pipe_req   = pipe_wr & (io_pipe_sel != 2'd3) & ~hazard;
        ld_req     = io_ld_resp_valid & (count != '0);
        grant_pipe = pipe_req & (~ld_req | (last_grant == GRANT_LD));
        grant_ld   = ld_req & (~pipe_req | (last_grant == GRANT_PIPE));

        io_pipe_ready     = ~hazard & (~pipe_req | grant_pipe);
        io_ld_resp_ready  = grant_ld;
        io_ld_issue_ready = (count != CNT_W'(LD_DEPTH));

        push = io_ld_issue_valid & io_ld_issue_ready;
        pop  = grant_ld;
    end

    // Queue payload needs no reset: liveness comes from head/count only.
    always_ff @(posedge clk) begin
        if (push)
            q_rd[tail] <= io_ld_issue_rd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            last_grant  <= GRANT_PIPE;
            io_rf_wen   <= 1'b0;
            io_rf_waddr <= '0;
            io_rf_wdata <= '0;
        end else begin
            if (push)
                tail <= tail + PTR_W'(1);
            if (pop)
                head <= head + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);

            if (pipe_req && ld_req)
                last_grant <= grant_ld ? GRANT_LD : GRANT_PIPE;

            if (grant_pipe) begin
                io_rf_wen   <= (io_pipe_rd != '0);
                io_rf_waddr <= io_pipe_rd;
                io_rf_wdata <= pipe_data;
            end else if (grant_ld) begin
                io_rf_wen   <= (q_rd[head] != '0);
                io_rf_waddr <= q_rd[head];
                io_rf_wdata <= io_ld_resp_data;
            end else begin
                io_rf_wen   <= 1'b0;
            end
        end
    end

    assign io_ld_pending = count;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter: pipe writes, load round-trip,
// round-robin conflicts, WAW hazard, full queue with x0, and mid-operation reset.
module tb_wb_port_arbiter;

    localparam int XLEN     = 32;
    localparam int REG_BITS = 5;
    localparam int LD_DEPTH = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                io_pipe_valid;
    logic [1:0]          io_pipe_sel;
    logic [REG_BITS-1:0] io_pipe_rd;
    logic                io_pipe_wen;
    logic [XLEN-1:0]     io_pipe_alu;
    logic [XLEN-1:0]     io_pipe_csr;
    logic [XLEN-1:0]     io_pipe_pc4;
    logic                io_pipe_ready;
    logic                io_ld_issue_valid;
    logic [REG_BITS-1:0] io_ld_issue_rd;
    logic                io_ld_issue_ready;
    logic                io_ld_resp_valid;
    logic [XLEN-1:0]     io_ld_resp_data;
    logic                io_ld_resp_ready;
    logic                io_rf_wen;
    logic [REG_BITS-1:0] io_rf_waddr;
    logic [XLEN-1:0]     io_rf_wdata;
    logic [1:0]          io_ld_pending;

    int checks = 0;
    int passes = 0;

    wb_port_arbiter #(.XLEN(XLEN), .REG_BITS(REG_BITS), .LD_DEPTH(LD_DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .io_pipe_valid     (io_pipe_valid),
        .io_pipe_sel       (io_pipe_sel),
        .io_pipe_rd        (io_pipe_rd),
        .io_pipe_wen       (io_pipe_wen),
        .io_pipe_alu       (io_pipe_alu),
        .io_pipe_csr       (io_pipe_csr),
        .io_pipe_pc4       (io_pipe_pc4),
        .io_pipe_ready     (io_pipe_ready),
        .io_ld_issue_valid (io_ld_issue_valid),
        .io_ld_issue_rd    (io_ld_issue_rd),
        .io_ld_issue_ready (io_ld_issue_ready),
        .io_ld_resp_valid  (io_ld_resp_valid),
        .io_ld_resp_data   (io_ld_resp_data),
        .io_ld_resp_ready  (io_ld_resp_ready),
        .io_rf_wen         (io_rf_wen),
        .io_rf_waddr       (io_rf_waddr),
        .io_rf_wdata       (io_rf_wdata),
        .io_ld_pending     (io_ld_pending)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge, so both comb and registered
    // outputs are sampled well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        io_pipe_valid     = 1'b0;
        io_pipe_sel       = 2'd0;
        io_pipe_rd        = '0;
        io_pipe_wen       = 1'b0;
        io_pipe_alu       = '0;
        io_pipe_csr       = '0;
        io_pipe_pc4       = '0;
        io_ld_issue_valid = 1'b0;
        io_ld_issue_rd    = '0;
        io_ld_resp_valid  = 1'b0;
        io_ld_resp_data   = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++; if (io_rf_wen !== 1'b0) $display("[TB] FAIL reset_wen: got %0b expected 0", io_rf_wen); else passes++;
        checks++; if (io_rf_waddr !== 5'd0) $display("[TB] FAIL reset_waddr: got %0d expected 0", io_rf_waddr); else passes++;
        checks++; if (io_rf_wdata !== 32'h0) $display("[TB] FAIL reset_wdata: got %h expected 0", io_rf_wdata); else passes++;
        checks++; if (io_ld_pending !== 2'd0) $display("[TB] FAIL reset_pending: got %0d expected 0", io_ld_pending); else passes++;
        checks++; if (io_ld_issue_ready !== 1'b1) $display("[TB] FAIL reset_issue_ready: got %0b expected 1", io_ld_issue_ready); else passes++;
    endtask

    task automatic test_pipe_writes();
        logic [REG_BITS-1:0] exp_rd;
        logic [XLEN-1:0]     exp_data;
        io_pipe_alu = 32'h11;
        io_pipe_csr = 32'h22;
        io_pipe_pc4 = 32'h104;
        for (int i = 0; i < 3; i++) begin
            io_pipe_valid = 1'b1;
            io_pipe_wen   = 1'b1;
            io_pipe_sel   = 2'(i);
            io_pipe_rd    = 5'(5 + i);
            exp_rd        = 5'(5 + i);
            exp_data      = (i == 0) ? 32'h11 : (i == 1) ? 32'h22 : 32'h104;
            #1;
            checks++; if (io_pipe_ready !== 1'b1) $display("[TB] FAIL pipe_ready[%0d]: got %0b expected 1", i, io_pipe_ready); else passes++;
            tick();
            checks++; if (io_rf_wen !== 1'b1) $display("[TB] FAIL pipe_wen[%0d]: got %0b expected 1", i, io_rf_wen); else passes++;
            checks++; if (io_rf_waddr !== exp_rd) $display("[TB] FAIL pipe_waddr[%0d]: got %0d expected %0d", i, io_rf_waddr, exp_rd); else passes++;
            checks++; if (io_rf_wdata !== exp_data) $display("[TB] FAIL pipe_wdata[%0d]: got %h expected %h", i, io_rf_wdata, exp_data); else passes++;
        end
        idle_inputs();
        tick();
        checks++; if (io_rf_wen !== 1'b0) $display("[TB] FAIL idle_wen: got %0b expected 0", io_rf_wen); else passes++;
        checks++; if (io_rf_waddr !== 5'd7) $display("[TB] FAIL idle_waddr_hold: got %0d expected 7", io_rf_waddr); else passes++;
        checks++; if (io_rf_wdata !== 32'h104) $display("[TB] FAIL idle_wdata_hold: got %h expected 00000104", io_rf_wdata); else passes++;
    endtask

    task automatic test_load_roundtrip();
        io_ld_issue_valid = 1'b1;
        io_ld_issue_rd    = 5'd9;
        #1;
        checks++; if (io_ld_issue_ready !== 1'b1) $display("[TB] FAIL rt_issue_ready: got %0b expected 1", io_ld_issue_ready); else passes++;
        tick();
        io_ld_issue_valid = 1'b0;
        checks++; if (io_ld_pending !== 2'd1) $display("[TB] FAIL rt_pending_1: got %0d expected 1", io_ld_pending); else passes++;
        tick();
        tick();
        tick();
        checks++; if (io_rf_wen !== 1'b0) $display("[TB] FAIL rt_wait_wen: got %0b expected 0", io_rf_wen); else passes++;
        io_ld_resp_valid = 1'b1;
        io_ld_resp_data  = 32'hDEADBEEF;
        #1;
        checks++; if (io_ld_resp_ready !== 1'b1) $display("[TB] FAIL rt_resp_ready: got %0b expected 1", io_ld_resp_ready); else passes++;
        tick();
        io_ld_resp_valid = 1'b0;
        checks++; if (io_rf_wen !== 1'b1) $display("[TB] FAIL rt_wen: got %0b expected 1", io_rf_wen); else passes++;
        checks++; if (io_rf_waddr !== 5'd9) $display("[TB] FAIL rt_waddr: got %0d expected 9", io_rf_waddr); else passes++;
        checks++; if (io_rf_wdata !== 32'hDEADBEEF) $display("[TB] FAIL rt_wdata: got %h expected deadbeef", io_rf_wdata); else passes++;
        checks++; if (io_ld_pending !== 2'd0) $display("[TB] FAIL rt_pending_0: got %0d expected 0", io_ld_pending); else passes++;
    endtask

    task automatic test_conflict();
        idle_inputs();
        io_ld_issue_valid = 1'b1;
        io_ld_issue_rd    = 5'd3;
        tick();
        io_ld_issue_rd    = 5'd4;
        tick();
        io_ld_issue_valid = 1'b0;
        checks++; if (io_ld_pending !== 2'd2) $display("[TB] FAIL cf_pending: got %0d expected 2", io_ld_pending); else passes++;

        // Cycle A: both request, last grant was PIPE, so the load wins.
        io_pipe_valid    = 1'b1;
        io_pipe_wen      = 1'b1;
        io_pipe_sel      = 2'd0;
        io_pipe_rd       = 5'd8;
        io_pipe_alu      = 32'h88;
        io_ld_resp_valid = 1'b1;
        io_ld_resp_data  = 32'hA3;
        #1;
        checks++; if (io_pipe_ready !== 1'b0) $display("[TB] FAIL cf_a_pipe_ready: got %0b expected 0", io_pipe_ready); else passes++;
        checks++; if (io_ld_resp_ready !== 1'b1) $display("[TB] FAIL cf_a_resp_ready: got %0b expected 1", io_ld_resp_ready); else passes++;
        tick();
        checks++; if (io_rf_waddr !== 5'd3 || io_rf_wdata !== 32'hA3) $display("[TB] FAIL cf_a_write: got %0d/%h expected 3/000000a3", io_rf_waddr, io_rf_wdata); else passes++;

        // Cycle B: the pipe gets its turn.
        io_ld_resp_data = 32'hA4;
        #1;
        checks++; if (io_pipe_ready !== 1'b1) $display("[TB] FAIL cf_b_pipe_ready: got %0b expected 1", io_pipe_ready); else passes++;
        checks++; if (io_ld_resp_ready !== 1'b0) $display("[TB] FAIL cf_b_resp_ready: got %0b expected 0", io_ld_resp_ready); else passes++;
        tick();
        checks++; if (io_rf_waddr !== 5'd8 || io_rf_wdata !== 32'h88) $display("[TB] FAIL cf_b_write: got %0d/%h expected 8/00000088", io_rf_waddr, io_rf_wdata); else passes++;

        // Cycle C: the waiting load goes next.
        io_pipe_alu = 32'h89;
        #1;
        checks++; if (io_pipe_ready !== 1'b0) $display("[TB] FAIL cf_c_pipe_ready: got %0b expected 0", io_pipe_ready); else passes++;
        checks++; if (io_ld_resp_ready !== 1'b1) $display("[TB] FAIL cf_c_resp_ready: got %0b expected 1", io_ld_resp_ready); else passes++;
        tick();
        checks++; if (io_rf_waddr !== 5'd4 || io_rf_wdata !== 32'hA4) $display("[TB] FAIL cf_c_write: got %0d/%h expected 4/000000a4", io_rf_waddr, io_rf_wdata); else passes++;
        checks++; if (io_ld_pending !== 2'd0) $display("[TB] FAIL cf_c_pending: got %0d expected 0", io_ld_pending); else passes++;

        // Cycle D: queue empty, the held pipe write goes through.
        io_ld_resp_valid = 1'b0;
        #1;
        checks++; if (io_pipe_ready !== 1'b1) $display("[TB] FAIL cf_d_pipe_ready: got %0b expected 1", io_pipe_ready); else passes++;
        tick();
        checks++; if (io_rf_wen !== 1'b1 || io_rf_waddr !== 5'd8 || io_rf_wdata !== 32'h89) $display("[TB] FAIL cf_d_write: got %0b/%0d/%h expected 1/8/00000089", io_rf_wen, io_rf_waddr, io_rf_wdata); else passes++;
        idle_inputs();
        tick();
    endtask

    task automatic test_hazard();
        // Same-cycle issue and pipe write to rd 12: the older pipe write proceeds.
        io_ld_issue_valid = 1'b1;
        io_ld_issue_rd    = 5'd12;
        io_pipe_valid     = 1'b1;
        io_pipe_wen       = 1'b1;
        io_pipe_sel       = 2'd0;
        io_pipe_rd        = 5'd12;
        io_pipe_alu       = 32'hB0;
        #1;
        checks++; if (io_pipe_ready !== 1'b1) $display("[TB] FAIL hz_same_cycle_ready: got %0b expected 1", io_pipe_ready); else passes++;
        tick();
        io_ld_issue_valid = 1'b0;
        io_pipe_alu       = 32'hC0;
        checks++; if (io_rf_waddr !== 5'd12 || io_rf_wdata !== 32'hB0) $display("[TB] FAIL hz_same_cycle_write: got %0d/%h expected 12/000000b0", io_rf_waddr, io_rf_wdata); else passes++;
        #1;
        checks++; if (io_pipe_ready !== 1'b0) $display("[TB] FAIL hz_stall_1: got %0b expected 0", io_pipe_ready); else passes++;
        tick();
        checks++; if (io_rf_wen !== 1'b0) $display("[TB] FAIL hz_stall_wen: got %0b expected 0", io_rf_wen); else passes++;
        io_pipe_sel = 2'd3;
        #1;
        checks++; if (io_pipe_ready !== 1'b0) $display("[TB] FAIL hz_stall_sel3: got %0b expected 0", io_pipe_ready); else passes++;
        io_pipe_sel      = 2'd0;
        io_ld_resp_valid = 1'b1;
        io_ld_resp_data  = 32'h12345678;
        #1;
        checks++; if (io_pipe_ready !== 1'b0) $display("[TB] FAIL hz_stall_2: got %0b expected 0", io_pipe_ready); else passes++;
        checks++; if (io_ld_resp_ready !== 1'b1) $display("[TB] FAIL hz_resp_ready: got %0b expected 1", io_ld_resp_ready); else passes++;
        tick();
        io_ld_resp_valid = 1'b0;
        checks++; if (io_rf_waddr !== 5'd12 || io_rf_wdata !== 32'h12345678) $display("[TB] FAIL hz_load_write: got %0d/%h expected 12/12345678", io_rf_waddr, io_rf_wdata); else passes++;
        #1;
        checks++; if (io_pipe_ready !== 1'b1) $display("[TB] FAIL hz_release: got %0b expected 1", io_pipe_ready); else passes++;
        tick();
        checks++; if (io_rf_wen !== 1'b1 || io_rf_waddr !== 5'd12 || io_rf_wdata !== 32'hC0) $display("[TB] FAIL hz_pipe_write: got %0b/%0d/%h expected 1/12/000000c0", io_rf_wen, io_rf_waddr, io_rf_wdata); else passes++;
        idle_inputs();
        tick();
    endtask

    task automatic test_full_x0();
        io_ld_issue_valid = 1'b1;
        io_ld_issue_rd    = 5'd0;
        tick();
        io_ld_issue_rd    = 5'd1;
        tick();
        io_ld_issue_rd    = 5'd2;
        #1;
        checks++; if (io_ld_issue_ready !== 1'b0) $display("[TB] FAIL full_issue_ready: got %0b expected 0", io_ld_issue_ready); else passes++;
        tick();
        checks++; if (io_ld_pending !== 2'd2) $display("[TB] FAIL full_pending: got %0d expected 2", io_ld_pending); else passes++;
        io_ld_resp_valid = 1'b1;
        io_ld_resp_data  = 32'h55;
        #1;
        checks++; if (io_ld_issue_ready !== 1'b0) $display("[TB] FAIL full_no_bypass: got %0b expected 0", io_ld_issue_ready); else passes++;
        checks++; if (io_ld_resp_ready !== 1'b1) $display("[TB] FAIL x0_resp_ready: got %0b expected 1", io_ld_resp_ready); else passes++;
        tick();
        io_ld_resp_valid = 1'b0;
        checks++; if (io_rf_wen !== 1'b0) $display("[TB] FAIL x0_wen: got %0b expected 0", io_rf_wen); else passes++;
        checks++; if (io_rf_waddr !== 5'd0 || io_rf_wdata !== 32'h55) $display("[TB] FAIL x0_addr_data: got %0d/%h expected 0/00000055", io_rf_waddr, io_rf_wdata); else passes++;
        checks++; if (io_ld_pending !== 2'd1) $display("[TB] FAIL x0_pending: got %0d expected 1", io_ld_pending); else passes++;
        checks++; if (io_ld_issue_ready !== 1'b1) $display("[TB] FAIL x0_issue_ready: got %0b expected 1", io_ld_issue_ready); else passes++;
        tick();
        io_ld_issue_valid = 1'b0;
        checks++; if (io_ld_pending !== 2'd2) $display("[TB] FAIL refill_pending: got %0d expected 2", io_ld_pending); else passes++;
    endtask

    task automatic test_reset_midop();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (io_ld_pending !== 2'd0) $display("[TB] FAIL rst_mid_pending: got %0d expected 0", io_ld_pending); else passes++;
        checks++; if (io_rf_wen !== 1'b0) $display("[TB] FAIL rst_mid_wen: got %0b expected 0", io_rf_wen); else passes++;
        checks++; if (io_rf_waddr !== 5'd0 || io_rf_wdata !== 32'h0) $display("[TB] FAIL rst_mid_addr_data: got %0d/%h expected 0/00000000", io_rf_waddr, io_rf_wdata); else passes++;
        io_ld_resp_valid = 1'b1;
        io_ld_resp_data  = 32'hFACE;
        #1;
        checks++; if (io_ld_resp_ready !== 1'b0) $display("[TB] FAIL rst_mid_resp_ready: got %0b expected 0", io_ld_resp_ready); else passes++;
        tick();
        io_ld_resp_valid = 1'b0;
        checks++; if (io_rf_wen !== 1'b0) $display("[TB] FAIL rst_mid_resp_wen: got %0b expected 0", io_rf_wen); else passes++;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_pipe_writes();
        test_load_roundtrip();
        test_conflict();
        test_hazard();
        test_full_x0();
        test_reset_midop();
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port of the core.
- Shares that port between two sources:
  - same-cycle pipeline writebacks: ALU, CSR and PC+4 results, selected by the 2-bit writeback select.
  - in-order, multi-cycle load responses from the data memory interface.
- Tracks outstanding load destinations in a small in-order queue.
- Arbitrates port conflicts round-robin.
- Stalls the pipeline on a write-after-write hazard against a pending load.
- Registers the final write command.

Parameters:
- XLEN, 32, data width of the write port and all result inputs.
- REG_BITS, 5, register address width.
- LD_DEPTH, 2, maximum outstanding loads (power of two, >=2).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- io_pipe_valid  input  1  pipeline writeback request present.
- io_pipe_sel  input  2  writeback select: 0=ALU, 1=CSR, 2=PC4, 3=MEM.
- io_pipe_rd  input  REG_BITS  destination register.
- io_pipe_wen  input  1  instruction writes a register.
- io_pipe_alu  input  XLEN  ALU result.
- io_pipe_csr  input  XLEN  CSR read data.
- io_pipe_pc4  input  XLEN  PC+4.
- io_pipe_ready  output  1  pipeline writeback accepted this cycle.
- io_ld_issue_valid  input  1  load issued to memory.
- io_ld_issue_rd  input  REG_BITS  load destination register.
- io_ld_issue_ready  output  1  queue can accept the issue.
- io_ld_resp_valid  input  1  load data returned (in order).
- io_ld_resp_data  input  XLEN  load data.
- io_ld_resp_ready  output  1  response consumed this cycle.
- io_rf_wen  output  1  register-file write enable (registered).
- io_rf_waddr  output  REG_BITS  register-file write address (registered).
- io_rf_wdata  output  XLEN  register-file write data (registered).
- io_ld_pending  output  clog2(LD_DEPTH)+1  outstanding load count.

Behaviour:
- Reset (synchronous, active-high):
  - queue empty, io_ld_pending=0.
  - io_rf_wen=0, io_rf_waddr=0, io_rf_wdata=0.
  - last_grant=PIPE.
  - Reset asserted mid-operation discards all queued loads. Responses arriving afterwards are refused (queue empty).
- Pipe request:
  - pipe_req = io_pipe_valid & io_pipe_wen & io_pipe_sel!=3.
  - Data mux: sel 0 -> io_pipe_alu, 1 -> io_pipe_csr, 2 -> io_pipe_pc4.
  - sel=3 is never a port request; the load path carries it. io_pipe_ready=1 for it unless the hazard below applies.
- Hazard:
  - Condition: io_pipe_valid & io_pipe_wen & io_pipe_rd!=0, and io_pipe_rd matches any valid queue entry.
  - Response: io_pipe_ready=0 and no pipe request is raised.
  - Applies to all sel values, including 3, so register writes stay in program order.
- Load request: ld_req = io_ld_resp_valid & queue non-empty.
  - io_ld_resp_valid with an empty queue: io_ld_resp_ready=0, ignored.
- Arbitration (combinational grant):
  - Only one requester: it wins.
  - Both request: the side opposite last_grant wins.
  - last_grant updates only on a conflict cycle.
  - No starvation: each side waits at most 1 cycle per conflict.
- Handshakes:
  - io_pipe_ready = !hazard & (!pipe_req | grant_pipe).
  - io_ld_resp_ready = grant_ld.
  - io_ld_issue_ready = queue not full.
  - An issue in the same cycle as a pop while full is refused; no bypass.
- Queue:
  - Push io_ld_issue_rd on issue_valid & issue_ready.
  - Pop head on grant_ld.
  - Push and pop may occur in the same cycle; count is unchanged.
  - Pointers wrap modulo LD_DEPTH.
  - A newly pushed rd participates in the hazard check from the next cycle.
  - Same-cycle issue and pipe write to the same rd: the pipe write proceeds, since it is older.
- Output register:
  - Latency 1 cycle from grant to io_rf_*.
  - io_rf_wen = granted & rd!=0.
  - Writes to x0 complete their handshake (load pops) but drive io_rf_wen=0.
  - io_rf_waddr and io_rf_wdata load on every grant. They hold when idle.
  - io_rf_wen is cleared in cycles without a grant.
- Load write data is io_ld_resp_data; address is the queue head rd.

Test Plan:
- Pipe-only writes: sel=0 alu=0x11 rd=5, then sel=1 csr=0x22 rd=6, then sel=2 pc4=0x104 rd=7 -> io_rf_wen=1 on the next cycle each time, addr/data 5/0x11, 6/0x22, 7/0x104; io_pipe_ready=1 throughout.
- Load round-trip: issue rd=9, 3 idle cycles, resp data=0xDEADBEEF -> resp_ready=1 same cycle; next cycle wen=1 addr=9 data=0xDEADBEEF; io_ld_pending goes 0->1->0.
- Conflict round-robin: two loads queued (rd 3, rd 4), responses back-to-back while pipe writes rd=8 are continuously valid -> grants alternate LD(3), PIPE(8), LD(4); pipe_ready pattern 0,1,...; no write is lost.
- Hazard: load to rd=12 outstanding; pipe sel=0 rd=12 -> io_pipe_ready=0 until the load write is granted; the pipe write is accepted the next cycle, and the port shows rd=12 load data then rd=12 ALU data.
- Full queue and x0: issue LD_DEPTH=2 loads (rd 0, rd 1), third issue -> issue_ready=0; response for rd 0 -> pops with io_rf_wen=0; issue_ready=1 the next cycle.
- Reset mid-op: queue holds 2 entries, pulse reset 1 cycle -> io_ld_pending=0, io_rf_wen=0; a subsequent resp_valid gets resp_ready=0.
